// File: rtl/octant_map_if.sv
// Signal bundle between the octant split / sin-cos core and the octant reconstruction stage.
// Valid-only stream, no ready: a word is transferred on any rising edge with ce=1 and its valid high.
interface octant_map_if #(
    parameter int W = 20
);
    logic         oct_valid;
    logic [2:0]   oct_in;
    logic         core_valid;
    logic [W-1:0] xs;
    logic [W-1:0] ys;
    logic         clr_err;
    logic [W-1:0] sin_out;
    logic [W-1:0] cos_out;
    logic         out_valid;
    logic         align_err;

    modport master (
        output oct_valid, oct_in, core_valid, xs, ys, clr_err,
        input  sin_out, cos_out, out_valid, align_err
    );

    modport slave (
        input  oct_valid, oct_in, core_valid, xs, ys, clr_err,
        output sin_out, cos_out, out_valid, align_err
    );
endinterface

// File: rtl/octant_map_pipe.sv
// Octant reconstruction: delays the octant bits to meet the sin/cos core output,
// then folds first-octant cos/sin into full-circle sin/cos, registered.
module octant_map_pipe #(
    parameter int W        = 20,
    parameter int CORE_LAT = 4,
    parameter int FMT      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    octant_map_if.slave bus
);
    localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

    logic [CORE_LAT-1:0]      vld_q;
    logic [CORE_LAT-1:0]      vld_d;
    logic [CORE_LAT-1:0][2:0] oct_q;
    logic [CORE_LAT-1:0][2:0] oct_d;

    logic         tail_vld;
    logic [2:0]   tail_oct;
    logic         swap;
    logic         sin_neg;
    logic         cos_neg;
    logic         hit;
    logic         mismatch;
    logic [W-1:0] sin_src;
    logic [W-1:0] cos_src;

    logic [W-1:0] sin_q;
    logic [W-1:0] sin_d;
    logic [W-1:0] cos_q;
    logic [W-1:0] cos_d;
    logic         out_valid_q;
    logic         out_valid_d;
    logic         align_err_q;
    logic         align_err_d;

    // Negating the most negative code would wrap back onto itself, so it clamps to +max.
    function automatic logic [W-1:0] sign_apply(input logic [W-1:0] v, input logic neg);
        logic [W-1:0] r;
        if (FMT == 1) begin
            r = {neg, v[W-1:1]};
        end else if (!neg) begin
            r = v;
        end else if (v == S_MIN) begin
            r = S_MAX;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    always_comb begin
        vld_d = vld_q;
        oct_d = oct_q;
        if (ce) begin
            vld_d[0] = bus.oct_valid;
            oct_d[0] = bus.oct_in;
            for (int i = 1; i < CORE_LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                oct_d[i] = oct_q[i-1];
            end
        end
    end

    assign tail_vld = vld_q[CORE_LAT-1];
    assign tail_oct = oct_q[CORE_LAT-1];

    // Octants 1,2,5,6 swap the roles of xs/ys; sin is negative in the lower half,
    // cos is negative in octants 2..5.
    always_comb begin
        swap     = tail_oct[0] ^ tail_oct[1];
        sin_neg  = tail_oct[2];
        cos_neg  = tail_oct[2] ^ tail_oct[1];
        sin_src  = swap ? bus.xs : bus.ys;
        cos_src  = swap ? bus.ys : bus.xs;
        hit      = tail_vld & bus.core_valid;
        mismatch = tail_vld ^ bus.core_valid;

        sin_d       = sin_q;
        cos_d       = cos_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = hit;
            if (hit) begin
                sin_d = sign_apply(sin_src, sin_neg);
                cos_d = sign_apply(cos_src, cos_neg);
            end
        end

        // A fresh error wins over a clear arriving in the same cycle.
        align_err_d = (align_err_q & ~bus.clr_err) | (ce & mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            oct_q       <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            out_valid_q <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            oct_q       <= oct_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            out_valid_q <= out_valid_d;
            align_err_q <= align_err_d;
        end
    end

    assign bus.sin_out   = sin_q;
    assign bus.cos_out   = cos_q;
    assign bus.out_valid = out_valid_q;
    assign bus.align_err = align_err_q;
endmodule

// File: tb/tb_octant_map_pipe.sv
// Bench for octant_map_pipe: two instances (two's complement and sign-magnitude) fed the
// same stream by a behavioural sin/cos core, checked against a scoreboard of expected samples.
module tb_octant_map_pipe;
  localparam int W = 20;
  localparam int L = 4;
  localparam logic [W-1:0] SMIN = 20'h80000;
  localparam logic [W-1:0] SMAX = 20'h7FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  int checks = 0;
  int errors = 0;

  octant_map_if #(.W(W)) bus0 ();
  octant_map_if #(.W(W)) bus1 ();

  assign bus1.oct_valid  = bus0.oct_valid;
  assign bus1.oct_in     = bus0.oct_in;
  assign bus1.core_valid = bus0.core_valid;
  assign bus1.xs         = bus0.xs;
  assign bus1.ys         = bus0.ys;
  assign bus1.clr_err    = bus0.clr_err;

  octant_map_pipe #(.W(W), .CORE_LAT(L), .FMT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus0)
  );
  octant_map_pipe #(.W(W), .CORE_LAT(L), .FMT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- core model + scoreboard state ----------------
  logic         cp_v [L];
  logic [W-1:0] cp_x [L];
  logic [W-1:0] cp_y [L];
  logic [2*W-1:0] exp0_q[$];
  logic [2*W-1:0] exp1_q[$];
  int             due_q[$];
  int             ce_cyc = 0;
  logic           last_ov;
  logic [W-1:0]   last_s0, last_c0, last_s1, last_c1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sgn(input logic [W-1:0] v, input bit neg, input bit fmt);
    if (fmt) return {neg, v[W-1:1]};
    if (!neg) return v;
    if (v == SMIN) return SMAX;
    return ~v + 1'b1;
  endfunction

  // Returns {sin, cos}
  function automatic logic [2*W-1:0] ref_map(input logic [2:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input bit fmt);
    case (o)
      3'd0:    return {sgn(y, 0, fmt), sgn(x, 0, fmt)};
      3'd1:    return {sgn(x, 0, fmt), sgn(y, 0, fmt)};
      3'd2:    return {sgn(x, 0, fmt), sgn(y, 1, fmt)};
      3'd3:    return {sgn(y, 0, fmt), sgn(x, 1, fmt)};
      3'd4:    return {sgn(y, 1, fmt), sgn(x, 1, fmt)};
      3'd5:    return {sgn(x, 1, fmt), sgn(y, 1, fmt)};
      3'd6:    return {sgn(x, 1, fmt), sgn(y, 0, fmt)};
      default: return {sgn(y, 1, fmt), sgn(x, 0, fmt)};
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_sample();
    case ($urandom_range(0, 7))
      0:       return SMIN;
      1:       return SMAX;
      2:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic void model_clear();
    exp0_q.delete();
    exp1_q.delete();
    due_q.delete();
    for (int i = 0; i < L; i++) begin
      cp_v[i] = 1'b0;
      cp_x[i] = '0;
      cp_y[i] = '0;
    end
    last_ov = 1'b0;
    last_s0 = '0; last_c0 = '0; last_s1 = '0; last_c1 = '0;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // cv_ovr < 0: core model drives core_valid; 0/1 forces it. exp_al: expected align_err after the edge.
  task automatic step(input bit c, input bit ov, input logic [2:0] o,
                      input logic [W-1:0] x, input logic [W-1:0] y,
                      input int cv_ovr, input bit clr, input bit push, input bit exp_al);
    logic [2*W-1:0] e0, e1;
    ce = c;
    bus0.oct_valid = ov;
    bus0.oct_in    = o;
    bus0.clr_err   = clr;
    if (c) begin
      bus0.core_valid = (cv_ovr < 0) ? cp_v[L-1] : cv_ovr[0];
      bus0.xs = bus0.core_valid ? cp_x[L-1] : W'($urandom);
      bus0.ys = bus0.core_valid ? cp_y[L-1] : W'($urandom);
    end else begin
      bus0.core_valid = 1'($urandom);
      bus0.xs = W'($urandom);
      bus0.ys = W'($urandom);
    end
    if (c && ov && push) begin
      exp0_q.push_back(ref_map(o, x, y, 1'b0));
      exp1_q.push_back(ref_map(o, x, y, 1'b1));
      due_q.push_back(ce_cyc + 1 + L);
    end
    @(posedge clk);
    #1;
    if (c) begin
      ce_cyc++;
      for (int i = L - 1; i > 0; i--) begin
        cp_v[i] = cp_v[i-1];
        cp_x[i] = cp_x[i-1];
        cp_y[i] = cp_y[i-1];
      end
      cp_v[0] = ov;
      cp_x[0] = x;
      cp_y[0] = y;
      last_ov = (due_q.size() > 0) && (due_q[0] == ce_cyc);
      if (last_ov) begin
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        void'(due_q.pop_front());
        {last_s0, last_c0} = e0;
        {last_s1, last_c1} = e1;
      end
    end
    check("out_valid_fmt0", W'(bus0.out_valid), W'(last_ov));
    check("out_valid_fmt1", W'(bus1.out_valid), W'(last_ov));
    check("sin_fmt0", bus0.sin_out, last_s0);
    check("cos_fmt0", bus0.cos_out, last_c0);
    check("sin_fmt1", bus1.sin_out, last_s1);
    check("cos_fmt1", bus1.cos_out, last_c1);
    check("align_err_fmt0", W'(bus0.align_err), W'(exp_al));
    check("align_err_fmt1", W'(bus1.align_err), W'(exp_al));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, '0, '0, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    step(1'b1, 1'b1, o, x, y, -1, 1'b0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", W'(bus0.out_valid), '0);
    check("rst_sin", bus0.sin_out, '0);
    check("rst_cos", bus0.cos_out, '0);
    check("rst_align", W'(bus0.align_err), '0);
    check("rst_sin_fmt1", bus1.sin_out, '0);
    check("rst_cos_fmt1", bus1.cos_out, '0);
    model_clear();
    ce = 1'b0;
    bus0.oct_valid = 1'b0; bus0.oct_in = '0; bus0.core_valid = 1'b0;
    bus0.xs = '0; bus0.ys = '0; bus0.clr_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_clear();
    bus0.oct_valid = 1'b0; bus0.oct_in = '0; bus0.core_valid = 1'b0;
    bus0.xs = '0; bus0.ys = '0; bus0.clr_err = 1'b0;
    #1;
    do_reset();

    // Octant sweep, back to back
    for (int o = 0; o < 8; o++) issue(3'(o), 20'h30000, 20'h10000);
    idle(L + 3);

    // Saturation of the most negative code on either input
    issue(3'd4, 20'h30000, SMIN);
    issue(3'd5, SMIN, 20'h10000);
    issue(3'd2, 20'h12345, SMIN);
    idle(L + 3);

    // Stall for 3 cycles mid-burst while outputs are valid
    for (int i = 0; i < 10; i++) begin
      if (i == 6)
        for (int k = 0; k < 3; k++)
          step(1'b0, 1'($urandom), 3'($urandom), rnd_sample(), rnd_sample(), -1, 1'b0, 1'b0, 1'b0);
      issue(3'($urandom), rnd_sample(), rnd_sample());
    end
    idle(L + 3);

    // Reset mid-stream drops in-flight tokens
    for (int i = 0; i < 3; i++) issue(3'($urandom), rnd_sample(), rnd_sample());
    do_reset();
    idle(2);
    issue(3'd3, 20'h30000, 20'h10000);
    idle(L + 3);

    // Core output one cycle early: two mismatches, sticky flag, clear, clear-vs-set
    step(1'b1, 1'b1, 3'd1, 20'h30000, 20'h10000, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < L - 2; i++) step(1'b1, 1'b0, 3'd0, '0, '0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd0, '0, '0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd0, '0, '0, -1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, '0, '0, -1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd0, '0, '0, -1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd0, '0, '0, -1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, '0, '0, -1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Random traffic with random stalls
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 2)
        step(1'b0, 1'($urandom), 3'($urandom), rnd_sample(), rnd_sample(), -1, 1'b0, 1'b0, 1'b0);
      else
        step(1'b1, 1'($urandom), 3'($urandom), rnd_sample(), rnd_sample(), -1, 1'b0, 1'b1, 1'b0);
    end
    idle(L + 3);

    check("scoreboard_drained", W'(due_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
